abm_sync_notifier: RTL

//  Generalised N-channel successor to the two-block ABM update notifier.

---
 rtl/abm_pkg.sv | 18 +
 rtl/abm_sync_notifier_if.sv | 28 ++
 rtl/abm_collect_timer.sv | 35 +++
 rtl/abm_sync_notifier.sv | 113 +++++++++++
 4 files changed

// File: rtl/abm_pkg.sv
// Shared types and helpers for the ABM update notifier slice.
// Latency: n/a (package). Backpressure: n/a.
// Contents: FSM state type, channel-count ceiling, timer width helper.
package abm_pkg;

   typedef enum logic {
      ABM_IDLE    = 1'b0,
      ABM_COLLECT = 1'b1
   } abm_state_t;

   localparam int ABM_MAX_CH = 32;

   // A timeout of 0 still needs a 1-bit vector so declarations stay legal.
   function automatic int abm_timer_w(input int tmo);
      return (tmo < 1) ? 1 : $clog2(tmo + 1);
   endfunction

endpackage

// File: rtl/abm_sync_notifier_if.sv
// Bundle between the ABM block writers / consumer and the notifier.
// Latency: n/a (wires only). Backpressure: none, strobes are fire-and-forget.
// master: drives ch_enable/ch_updated, observes strobes and status; slave: the notifier.
interface abm_sync_notifier_if #(
   parameter int NUM_CH = 2,
   parameter int CNT_W  = 16
);

   logic [NUM_CH-1:0] ch_enable;
   logic [NUM_CH-1:0] ch_updated;
   logic              abm_ready;
   logic              abm_timeout;
   logic              overrun;
   logic [NUM_CH-1:0] pending;
   logic [NUM_CH-1:0] missing;
   logic [CNT_W-1:0]  ready_count;

   modport master (
      output ch_enable, ch_updated,
      input  abm_ready, abm_timeout, overrun, pending, missing, ready_count
   );

   modport slave (
      input  ch_enable, ch_updated,
      output abm_ready, abm_timeout, overrun, pending, missing, ready_count
   );

endinterface

// File: rtl/abm_collect_timer.sv
// Collection-age timer: counts cycles since the first update of an open set.
// Latency: tc_o reflects the registered count (no extra delay). Backpressure: none.
// Ports: clk, resetn (sync, active-low), clear_i (to 0, wins), load_i (to 1), en_i (count up), tc_o (count == TIMEOUT_CYCLES).
module abm_collect_timer
   import abm_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1
) (
   input  logic clk,
   input  logic resetn,
   input  logic clear_i,
   input  logic load_i,
   input  logic en_i,
   output logic tc_o
);

   localparam int            TW   = abm_timer_w(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TERM = TW'(TIMEOUT_CYCLES);

   logic [TW-1:0] timer_q;

   // Saturates at the terminal count so the flag can never be missed by a wrap.
   always_ff @(posedge clk) begin
      if (!resetn || clear_i) begin
         timer_q <= '0;
      end else if (load_i) begin
         timer_q <= TW'(1);
      end else if (en_i && (timer_q != TERM)) begin
         timer_q <= timer_q + TW'(1);
      end
   end

   assign tc_o = (timer_q == TERM);

endmodule

// File: rtl/abm_sync_notifier.sv
// Collects per-channel ABM update strobes and emits one abm_ready per complete enabled set.
// Latency: last required update sampled at edge N -> abm_ready in cycle N+1; all outputs registered.
// Backpressure: none; duplicates flag overrun, stale sets are abandoned by the optional timeout.
// Ports: clk, resetn (sync, active-low), bus (slave modport: ch_enable, ch_updated in;
//        abm_ready, abm_timeout, overrun, pending, missing, ready_count out).
module abm_sync_notifier
   import abm_pkg::*;
#(
   parameter int NUM_CH         = 2,
   parameter int TIMEOUT_CYCLES = 0,
   parameter int CNT_W          = 16
) (
   input  logic                 clk,
   input  logic                 resetn,
   abm_sync_notifier_if.slave   bus
);

   abm_state_t        state_q;
   logic [NUM_CH-1:0] pending_q;
   logic [NUM_CH-1:0] missing_q;
   logic [CNT_W-1:0]  count_q;
   logic              ready_q;
   logic              timeout_q;
   logic              overrun_q;

   logic [NUM_CH-1:0] upd;
   logic [NUM_CH-1:0] nxt;
   logic              en_none;
   logic              done;
   logic              tmo_hit;

   // Disabled channels never contribute; done is re-evaluated against the live mask,
   // so shrinking the mask can complete a set with no new update.
   always_comb begin
      upd     = bus.ch_updated & bus.ch_enable;
      nxt     = pending_q | upd;
      en_none = (bus.ch_enable == '0);
      done    = !en_none && ((nxt & bus.ch_enable) == bus.ch_enable);
   end

   generate
      if (TIMEOUT_CYCLES != 0) begin : g_timer
         logic load;
         logic clear;

         // Start counting at 1 on the first update; the timer sits at 0 whenever no set is open.
         assign load  = (state_q == ABM_IDLE) && !done && (upd != '0);
         assign clear = (state_q == ABM_IDLE) ? !load : (done || tmo_hit || en_none);

         abm_collect_timer #(
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
         ) u_timer (
            .clk     (clk),
            .resetn  (resetn),
            .clear_i (clear),
            .load_i  (load),
            .en_i    (state_q == ABM_COLLECT),
            .tc_o    (tmo_hit)
         );
      end else begin : g_no_timer
         assign tmo_hit = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q   <= ABM_IDLE;
         pending_q <= '0;
         missing_q <= '0;
         count_q   <= '0;
         ready_q   <= 1'b0;
         timeout_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         ready_q   <= 1'b0;
         timeout_q <= 1'b0;
         // Duplicate is flagged but not counted; the pending bit simply stays set.
         overrun_q <= |(upd & pending_q);

         if (en_none) begin
            state_q   <= ABM_IDLE;
            pending_q <= '0;
         end else if (done) begin
            // Checked before timeout so a set completing on its deadline still counts.
            ready_q   <= 1'b1;
            count_q   <= count_q + CNT_W'(1);
            pending_q <= '0;
            state_q   <= ABM_IDLE;
         end else if (state_q == ABM_IDLE) begin
            if (upd != '0) begin
               pending_q <= upd;
               state_q   <= ABM_COLLECT;
            end
         end else if (tmo_hit) begin
            timeout_q <= 1'b1;
            missing_q <= bus.ch_enable & ~nxt;
            pending_q <= '0;
            state_q   <= ABM_IDLE;
         end else begin
            // Masking here drops pending bits of channels disabled mid-set.
            pending_q <= nxt & bus.ch_enable;
         end
      end
   end

   assign bus.abm_ready   = ready_q;
   assign bus.abm_timeout = timeout_q;
   assign bus.overrun     = overrun_q;
   assign bus.pending     = pending_q;
   assign bus.missing     = missing_q;
   assign bus.ready_count = count_q;

endmodule
